// File: rtl/line_tracker_fsm.sv
// Line-following navigation controller: sensor sync/debounce, car state machine,
// intersection counting and turn selection. Optional turn watchdog: LINE_TRACKER_WATCHDOG_EN.
module line_tracker_fsm #(
  parameter logic [15:0] DEBOUNCE      = 16'd1000,
  parameter logic [23:0] COUNT_CYCLES  = 24'd10000000,
  parameter logic [23:0] TURN_MIN      = 24'd2000000,
  parameter logic [23:0] CHOOSE_CYCLES = 24'd1000000,
  parameter logic [23:0] LOST_CYCLES   = 24'd5000000,
  parameter logic [23:0] BACK_CYCLES   = 24'd3000000,
  parameter logic [7:0]  TURN_MASK     = 8'b0000_0000,
  parameter logic [3:0]  STOP_AT       = 4'd8,
  parameter logic [23:0] TURN_TIMEOUT  = 24'd8000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] sensor,
  output logic [4:0] mode,
  output logic [4:0] lastMode,
  output logic [3:0] isect_cnt,
  output logic [2:0] sensor_f
);

  typedef enum logic [4:0] {
    S_IDLE         = 5'd0,
    S_START        = 5'd1,
    S_COUNT        = 5'd2,
    S_STRAIGHT     = 5'd3,
    S_CHOOSE       = 5'd4,
    S_LEFT         = 5'd5,
    S_RIGHT        = 5'd6,
    S_BACK         = 5'd7,
    S_LITTLE_LEFT  = 5'd8,
    S_LITTLE_RIGHT = 5'd9,
    S_STOP         = 5'd30,
    S_ERROR        = 5'd31
  } state_t;

`ifdef LINE_TRACKER_WATCHDOG_EN
  localparam logic WATCHDOG_ON = 1'b1;
`else
  localparam logic WATCHDOG_ON = 1'b0;
`endif

  state_t      state;
  state_t      state_nx;
  logic        start_s1, start_s2, start_d;
  logic        start_p;
  logic [2:0]  sensor_s1, sensor_s2;
  logic [15:0] deb_cnt [0:2];
  logic [23:0] timer;
  logic [23:0] lost_cnt;
  logic        tracking;

  // Turn direction for the intersection just counted; counts beyond 8 default to LEFT.
  function automatic logic mask_bit(input logic [3:0] n);
    logic [3:0] nm1;
    nm1 = n - 4'd1;
    if (n >= 4'd1 && n <= 4'd8) begin
      mask_bit = TURN_MASK[nm1[2:0]];
    end else begin
      mask_bit = 1'b0;
    end
  endfunction

  assign start_p  = start_s2 & ~start_d;
  assign mode     = state;
  assign tracking = (state == S_STRAIGHT) || (state == S_LITTLE_LEFT) ||
                    (state == S_LITTLE_RIGHT);

  // Two-flop synchronizers plus the delayed start copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      start_d   <= 1'b0;
      sensor_s1 <= 3'b000;
      sensor_s2 <= 3'b000;
    end else begin
      start_s1  <= start;
      start_s2  <= start_s1;
      start_d   <= start_s2;
      sensor_s1 <= sensor;
      sensor_s2 <= sensor_s1;
    end
  end

  // Per-bit debounce: a bit flips only after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= 16'd0;
      end
      sensor_f <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sensor_s2[i] != sensor_f[i]) begin
          if (deb_cnt[i] == DEBOUNCE - 16'd1) begin
            sensor_f[i] <= sensor_s2[i];
            deb_cnt[i]  <= 16'd0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 16'd1;
          end
        end else begin
          deb_cnt[i] <= 16'd0;
        end
      end
    end
  end

  // Next-state logic; the timer counts cycles since the current state was entered.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_p) state_nx = S_START;
        else         state_nx = S_IDLE;
      end
      S_START: state_nx = S_COUNT;
      S_COUNT: begin
        if (timer == COUNT_CYCLES - 24'd1) state_nx = S_STRAIGHT;
        else                                state_nx = S_COUNT;
      end
      S_STRAIGHT, S_LITTLE_LEFT, S_LITTLE_RIGHT: begin
        case (sensor_f)
          3'b010:  state_nx = S_STRAIGHT;
          3'b110:  state_nx = S_LITTLE_LEFT;
          3'b011:  state_nx = S_LITTLE_RIGHT;
          3'b100:  state_nx = S_LEFT;
          3'b001:  state_nx = S_RIGHT;
          3'b111:  state_nx = S_CHOOSE;
          3'b101:  state_nx = S_ERROR;
          3'b000: begin
            if (lost_cnt == LOST_CYCLES - 24'd1) state_nx = S_BACK;
            else                                  state_nx = state;
          end
          default: state_nx = state;
        endcase
      end
      S_CHOOSE: begin
        // isect_cnt already holds the incremented value here.
        if (isect_cnt == STOP_AT)                  state_nx = S_STOP;
        else if (timer == CHOOSE_CYCLES - 24'd1)   state_nx = mask_bit(isect_cnt) ? S_RIGHT : S_LEFT;
        else                                       state_nx = S_CHOOSE;
      end
      S_LEFT, S_RIGHT: begin
        if (timer >= TURN_MIN - 24'd1 && sensor_f[1])                  state_nx = S_STRAIGHT;
        else if (WATCHDOG_ON && timer == TURN_TIMEOUT - 24'd1)         state_nx = S_ERROR;
        else                                                           state_nx = state;
      end
      S_BACK: begin
        if (timer == BACK_CYCLES - 24'd1) state_nx = S_STRAIGHT;
        else                               state_nx = S_BACK;
      end
      S_STOP, S_ERROR: begin
        if (start_p) state_nx = S_IDLE;
        else         state_nx = state;
      end
      default: state_nx = S_ERROR;
    endcase
  end

  // State, history, timers and intersection counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lastMode  <= 5'd0;
      timer     <= 24'd0;
      lost_cnt  <= 24'd0;
      isect_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        lastMode <= state;
        timer    <= 24'd0;
      end else if (timer != 24'hFF_FFFF) begin
        timer <= timer + 24'd1;
      end else begin
        timer <= timer;
      end

      if (tracking && sensor_f == 3'b000 && state_nx == state && lost_cnt != 24'hFF_FFFF) begin
        lost_cnt <= lost_cnt + 24'd1;
      end else if (tracking && sensor_f == 3'b000 && state_nx == state) begin
        lost_cnt <= lost_cnt;
      end else begin
        lost_cnt <= 24'd0;
      end

      if (state_nx == S_CHOOSE && state != S_CHOOSE) begin
        isect_cnt <= (isect_cnt == 4'd15) ? 4'd15 : isect_cnt + 4'd1;
      end else if (state_nx == S_IDLE && state != S_IDLE) begin
        isect_cnt <= 4'd0;
      end else begin
        isect_cnt <= isect_cnt;
      end
    end
  end

endmodule
